// File: rtl/mram_pkg.sv
// Shared configuration, request payload and address decode for the banked MRAM model.
package mram_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned BANK_DEPTH = 1024;
    localparam int unsigned READ_LAT   = 2;
    localparam int unsigned WRITE_LAT  = 8;
    localparam int unsigned PWRUP_LAT  = 16;

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned BYTE_OFS  = $clog2(NUM_BYTES);
    localparam int unsigned BANK_LOG2 = $clog2(NUM_BANKS);
    localparam int unsigned BANK_BITS = (BANK_LOG2 > 0) ? BANK_LOG2 : 1;
    localparam int unsigned ROW_BITS  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int unsigned NUM_WORDS = NUM_BANKS * BANK_DEPTH;
    localparam int unsigned BUSY_BITS = $clog2(WRITE_LAT + 1);
    localparam int unsigned PWR_BITS  = $clog2(PWRUP_LAT + 1);

    typedef enum logic [1:0] {
        PWR_OFF,
        PWR_WAKE,
        PWR_READY
    } pwr_state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [NUM_BYTES-1:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [BANK_BITS-1:0] bank;
        logic [ROW_BITS-1:0]  row;
        logic                 in_range;
    } decode_t;

    // Word index is compared at full address width so high addresses never alias.
    function automatic decode_t addr_decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        decode_t               d;
        word       = addr >> BYTE_OFS;
        d.bank     = BANK_BITS'(word & ADDR_WIDTH'(NUM_BANKS - 1));
        d.row      = ROW_BITS'(word >> BANK_LOG2);
        d.in_range = (word < ADDR_WIDTH'(NUM_WORDS));
        return d;
    endfunction

endpackage

// File: rtl/mram_bank.sv
// One MRAM bank: non-volatile storage, write busy window with deferred commit, async read port.
module mram_bank
    import mram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [ROW_BITS-1:0]   wr_row,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_BYTES-1:0]  wr_strb,
    input  logic [ROW_BITS-1:0]   rd_row,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [BUSY_BITS-1:0]  cnt;
    logic [ROW_BITS-1:0]   pend_row;
    logic [DATA_WIDTH-1:0] pend_data;
    logic [NUM_BYTES-1:0]  pend_strb;
    logic                  commit;

    // Busy window counts down from WRITE_LAT; reset or power loss abandons the pending write.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (wr_en) begin
            cnt  <= BUSY_BITS'(WRITE_LAT);
            busy <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - BUSY_BITS'(1);
            if (cnt == BUSY_BITS'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pend_row  <= wr_row;
            pend_data <= wr_data;
            pend_strb <= wr_strb;
        end
    end

    assign commit = ~rst & ~flush & ~wr_en & (cnt == BUSY_BITS'(1));

    // Array is never reset: contents survive rst and power cycling.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (pend_strb[b]) begin
                    mem[pend_row][8*b +: 8] <= pend_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_row];

endmodule

// File: rtl/mram_banked_model.sv
// Banked MRAM macro model: power sequencing, request handshake, bank array and read pipeline.
module mram_banked_model
    import mram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwr_on,
    output logic                  pwr_ready,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_BYTES-1:0]  req_wstrb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  wr_err,
    output logic [NUM_BANKS-1:0]  bank_busy
);

    req_t                  req;
    decode_t               dec;
    logic                  flush;
    logic                  accept;
    logic                  wr_acc;
    logic                  rd_acc;
    pwr_state_t            state;
    pwr_state_t            state_nx;
    logic [PWR_BITS-1:0]   cnt;
    logic [PWR_BITS-1:0]   cnt_nx;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic                  src_vld;
    logic                  src_err;
    logic [BANK_BITS-1:0]  src_bank;
    logic [ROW_BITS-1:0]   src_row;

    assign req = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
    assign dec = addr_decode(req.addr);

    // A handshake in the cycle pwr_on drops is discarded along with everything in flight.
    assign flush     = ~pwr_on;
    assign req_ready = pwr_ready & (~dec.in_range | ~bank_busy[dec.bank]);
    assign accept    = req_valid & req_ready & pwr_on;
    assign wr_acc    = accept & req.write & dec.in_range;
    assign rd_acc    = accept & ~req.write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_OFF;
            cnt       <= '0;
            pwr_ready <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pwr_ready <= (state_nx == PWR_READY);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            PWR_OFF: begin
                if (pwr_on) begin
                    cnt_nx   = PWR_BITS'(1);
                    state_nx = (PWRUP_LAT == 1) ? PWR_READY : PWR_WAKE;
                end
            end
            PWR_WAKE: begin
                if (!pwr_on) begin
                    cnt_nx   = '0;
                    state_nx = PWR_OFF;
                end else begin
                    cnt_nx = cnt + PWR_BITS'(1);
                    if (cnt_nx == PWR_BITS'(PWRUP_LAT)) begin
                        state_nx = PWR_READY;
                    end
                end
            end
            PWR_READY: begin
                if (!pwr_on) begin
                    cnt_nx   = '0;
                    state_nx = PWR_OFF;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = PWR_OFF;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic bank_wr;
        assign bank_wr = wr_acc && (dec.bank == BANK_BITS'(i));

        mram_bank u_bank (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .wr_en   (bank_wr),
            .wr_row  (dec.row),
            .wr_data (req.wdata),
            .wr_strb (req.wstrb),
            .rd_row  (src_row),
            .rd_data (bank_rdata[i]),
            .busy    (bank_busy[i])
        );
    end

    // Read address travels READ_LAT-1 stages, then the array is sampled into the response register.
    if (READ_LAT > 1) begin : g_pipe
        localparam int unsigned DEPTH = READ_LAT - 1;
        logic [DEPTH-1:0]     vld_q;
        logic [DEPTH-1:0]     err_q;
        logic [BANK_BITS-1:0] bank_q [DEPTH];
        logic [ROW_BITS-1:0]  row_q  [DEPTH];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= rd_acc;
                for (int k = 1; k < DEPTH; k++) begin
                    vld_q[k] <= vld_q[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            err_q[0]  <= ~dec.in_range;
            bank_q[0] <= dec.bank;
            row_q[0]  <= dec.row;
            for (int k = 1; k < DEPTH; k++) begin
                err_q[k]  <= err_q[k-1];
                bank_q[k] <= bank_q[k-1];
                row_q[k]  <= row_q[k-1];
            end
        end

        assign src_vld  = vld_q[DEPTH-1];
        assign src_err  = err_q[DEPTH-1];
        assign src_bank = bank_q[DEPTH-1];
        assign src_row  = row_q[DEPTH-1];
    end else begin : g_direct
        assign src_vld  = rd_acc;
        assign src_err  = ~dec.in_range;
        assign src_bank = dec.bank;
        assign src_row  = dec.row;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wr_err    <= 1'b0;
        end else begin
            rsp_valid <= src_vld & pwr_on;
            rsp_err   <= src_vld & pwr_on & src_err;
            wr_err    <= accept & req.write & ~dec.in_range;
            if (src_vld && pwr_on) begin
                rsp_rdata <= src_err ? '0 : bank_rdata[src_bank];
            end
        end
    end

endmodule

// File: tb/tb_mram_banked_model.sv
// Scoreboard bench for mram_banked_model: directed scenarios plus randomized traffic vs a word-level model.
module tb_mram_banked_model;
    import mram_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  pwr_on;
    logic                  pwr_ready;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [NUM_BYTES-1:0]  req_wstrb;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  wr_err;
    logic [NUM_BANKS-1:0]  bank_busy;

    mram_banked_model dut (
        .clk       (clk),
        .rst       (rst),
        .pwr_on    (pwr_on),
        .pwr_ready (pwr_ready),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wr_err    (wr_err),
        .bank_busy (bank_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        rq[$];
    int          wq[$];
    logic [63:0] model [int];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] strb);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a response or write error.
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (rst === 1'b0) begin
            if (rsp_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = rq.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(e.due));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    check("rsp_rdata", rsp_rdata, e.data);
                end
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                e = rq.pop_front();
                check("rsp_missing", 64'(rsp_valid), 64'd1);
            end
            if (wr_err === 1'b1) begin
                if (wq.size() == 0) begin
                    check("wr_err_unexpected", 64'(wr_err), 64'd0);
                end else begin
                    d = wq.pop_front();
                    check("wr_err_cycle", 64'(cyc), 64'(d));
                end
            end else if (wq.size() > 0 && wq[0] <= cyc) begin
                d = wq.pop_front();
                check("wr_err_missing", 64'(wr_err), 64'd1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request, hold until accepted, and record the expected outcome when tracked.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wstrb, input bit track, output int acc);
        logic [31:0] word;
        logic        inr;
        exp_t        e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        acc = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            check("req_accept_timeout", 64'(req_ready), 64'd1);
        end else if (track) begin
            word = addr >> 3;
            inr  = (word < 32'd4096);
            if (wr) begin
                if (inr) model[int'(word)] = merge(model.exists(int'(word)) ? model[int'(word)] : 64'd0,
                                                   wdata, wstrb);
                else wq.push_back(acc + 1);
            end else begin
                e.due  = acc + READ_LAT;
                e.err  = !inr;
                e.data = inr ? model[int'(word)] : 64'd0;
                rq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_pwr();
        bit seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (pwr_ready === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("pwr_ready_timeout", 64'(pwr_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (rq.size() == 0 && wq.size() == 0) break;
            idle(1);
        end
        check("drain_empty", 64'(rq.size() + wq.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_pwr_ready"}, 64'(pwr_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        check({tag, "_wr_err"}, 64'(wr_err), 64'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
        check({tag, "_bank_busy"}, 64'(bank_busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rise, bad, a0, a1, acc, r;
        int b[4];
        logic [31:0] word, addr;
        rst = 1'b1; pwr_on = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // Power-up latency and no acceptance before pwr_ready.
        c0 = cyc; pwr_on = 1'b1; req_addr = 32'h40; rise = -1; bad = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (pwr_ready === 1'b1) begin
                rise = cyc;
                break;
            end
            if (req_ready !== 1'b0) bad++;
        end
        check("pwrup_latency", 64'(rise - c0), 64'(PWRUP_LAT));
        check("ready_before_pwr", 64'(bad), 64'd0);
        @(posedge clk);
        #1;

        // Full write then read stalls for the busy window.
        do_req(1'b1, 32'h40, 64'h1122334455667788, 8'hFF, 1, a0);
        @(negedge clk);
        check("busy_after_write", 64'(bank_busy), 64'b0001);
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h40, '0, '0, 1, a1);
        check("read_stall_cycle", 64'(a1 - a0), 64'(WRITE_LAT + 1));

        do_req(1'b1, 32'h40, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1, acc);
        do_req(1'b0, 32'h40, '0, '0, 1, acc);

        // Back-to-back writes across banks, then a same-bank stall.
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 32'(i * 8), {$urandom, $urandom}, 8'hFF, 1, b[i]);
        check("b2b_accept_span", 64'(b[3] - b[0]), 64'd3);
        do_req(1'b1, 32'h20, {$urandom, $urandom}, 8'hFF, 1, acc);
        check("bank0_stall", 64'(acc - b[0]), 64'(WRITE_LAT + 1));
        for (int i = 0; i < 5; i++) do_req(1'b0, 32'(i * 8), '0, '0, 1, acc);
        drain();
        idle(10);

        // Out-of-range and boundary addresses.
        do_req(1'b0, 32'h8000, '0, '0, 1, acc);
        do_req(1'b1, 32'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, acc);
        @(negedge clk);
        check("oor_write_no_busy", 64'(bank_busy), 64'd0);
        @(posedge clk);
        #1;
        do_req(1'b1, 32'h7FF8, 64'hCAFE_F00D_1234_5678, 8'hFF, 1, acc);
        do_req(1'b0, 32'h7FFF, '0, '0, 1, acc);
        do_req(1'b0, 32'hFFFF_FFF8, '0, '0, 1, acc);
        drain();
        idle(10);

        // Power drop during a write with a read in flight.
        do_req(1'b1, 32'h40, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, a0);
        idle(1);
        do_req(1'b0, 32'h08, '0, '0, 0, r);
        check("drop_read_accept", 64'(r - a0), 64'd2);
        pwr_on = 1'b0;
        idle(1);
        pwr_on = 1'b1;
        @(negedge clk);
        check("drop_pwr_ready", 64'(pwr_ready), 64'd0);
        check("drop_bank_busy", 64'(bank_busy), 64'd0);
        check("drop_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        wait_pwr();
        do_req(1'b0, 32'h40, '0, '0, 1, acc);
        do_req(1'b0, 32'h08, '0, '0, 1, acc);
        drain();

        // Reset leaves the array intact.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check_reset_state("rst2");
        wait_pwr();
        do_req(1'b0, 32'h40, '0, '0, 1, acc);
        for (int i = 0; i < 5; i++) do_req(1'b0, 32'(i * 8), '0, '0, 1, acc);
        do_req(1'b0, 32'h7FF8, '0, '0, 1, acc);
        drain();

        // Randomized traffic over a small window plus out-of-range hits.
        for (int w = 0; w < 32; w++) do_req(1'b1, 32'(w * 8), {$urandom, $urandom}, 8'hFF, 1, acc);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) word = $urandom_range(4096, 32'h1FFF_FFFF);
            else word = $urandom_range(0, 31);
            addr = (word << 3) | 32'($urandom_range(0, 7));
            do_req(1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, 8'($urandom), 1, acc);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        idle(5);
        check("final_queues_empty", 64'(rq.size() + wq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mram_banked_model.md
Name: mram_banked_model

Overview:
- Next-generation behavioural MRAM macro model for the SoC memory subsystem; successor to the single-bank fixed-latency model.
- Multi-bank word storage with byte-strobe writes and a valid/ready request handshake.
- MRAM write cost is modelled as a per-bank busy window; power-up wake latency is modelled.
- Contents are non-volatile: neither reset nor power-off clears the array.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, word width; multiple of 8.
- NUM_BANKS, 4, bank count; power of 2, >=1.
- BANK_DEPTH, 1024, words per bank.
- READ_LAT, 2, accept-to-response cycles for reads; >=1.
- WRITE_LAT, 8, cycles a bank stays busy after accepting a write; >=1.
- PWRUP_LAT, 16, cycles from pwr_on rising to pwr_ready; >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pwr_on  in  1  macro supply enable.
- pwr_ready  out  1  macro powered and accepting requests.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  DATA_WIDTH/8  byte write enables.
- rsp_valid  out  1  one-cycle read response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; holds last value between pulses.
- rsp_err  out  1  qualifies rsp_valid: out-of-range read.
- wr_err  out  1  one-cycle pulse on accepting an out-of-range write.
- bank_busy  out  NUM_BANKS  per-bank write-in-progress flags.

Behaviour:
- Address mapping:
  - word = req_addr / (DATA_WIDTH/8); bank = word % NUM_BANKS; row = word / NUM_BANKS.
  - In range iff word < NUM_BANKS*BANK_DEPTH; computed in ADDR_WIDTH bits with no wrap (differs from the old modulo aliasing).
- Reset (rst=1 at posedge):
  - pwr_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0, bank_busy=0.
  - Read pipeline cleared; power counter=0; pending writes discarded.
  - Array contents are untouched.
- Power sequencing:
  - Power counter increments while pwr_on=1; pwr_ready=1 once it reaches PWRUP_LAT and stays 1 while pwr_on=1.
  - pwr_on=0 for one cycle: next cycle counter=0, pwr_ready=0, all in-flight reads dropped (no rsp_valid), all busy writes aborted (array unchanged), bank_busy=0.
- Handshake:
  - req_ready = pwr_ready & ~bank_busy[bank(req_addr)] (combinational).
  - Out-of-range addresses: ready = pwr_ready.
  - The requester holds all req_* stable while valid&~ready.
- Write:
  - On accept, the bank latches row/data/strobe and bank_busy[bank] is set for exactly WRITE_LAT cycles.
  - Commit occurs at the posedge ending the busy window: bytes with strobe=1 updated, others kept.
  - wstrb=0: busy window still runs; no data change.
  - Writes to different banks may overlap.
- Read:
  - On accept, array data is sampled READ_LAT cycles later and returned on rsp_valid.
  - Accept at cycle t gives rsp_valid at t+READ_LAT; one read per cycle, fully pipelined, in order.
  - A read to a busy bank stalls, so it never sees a pending write.
- Out-of-range:
  - Read: rsp_valid at t+READ_LAT with rsp_err=1, rsp_rdata=0.
  - Write: wr_err pulses at t+1; no bank is busied.
- pwr_on falling in the same cycle as a handshake: the request is dropped.

Decomposition:
- mram_pkg holds the bank-index/row/byte-count localparams, a req_t struct (write, addr, wdata, wstrb) and the addr->(bank,row,in_range) decode function.
- Sub-module mram_bank holds one bank: storage, busy down-counter, latched pending write, commit logic and the read port.
- The top module instantiates NUM_BANKS copies via generate and adds the power FSM (OFF, WAKE, READY) and the read pipeline.

Test Plan:
- Power-up: rst 2 cycles, pwr_on=1 -> pwr_ready rises exactly 16 cycles later; req_ready=0 before that.
- Write 0x1122334455667788 to addr 0x40 with wstrb=0xFF, then read 0x40 -> bank_busy[0] high 8 cycles; read accepted only after it clears; rsp_valid 2 cycles after accept with that data.
- Partial write wstrb=0x0F with data 0xAAAAAAAA_BBBBBBBB to 0x40, then read -> 0x11223344_BBBBBBBB.
- Back-to-back writes to 0x00, 0x08, 0x10, 0x18 (banks 0-3) -> all accepted on consecutive cycles; write to 0x20 (bank 0) stalls until bank 0 is free.
- Read 0x8000 (word 4096, out of range) -> rsp_err=1, rsp_rdata=0 at +2; write 0x8000 -> wr_err pulse at +1, no bank busy.
- Drop pwr_on 3 cycles into a write to 0x40, plus one read in flight -> no rsp_valid, old data retained after re-power; rst assertion never alters stored data.
